wb_trace_checker: RTL and testbench

//  Parametrised writeback-stream checker for the pipelined core benches. Holds up to DEPTH expected

---
 rtl/wb_trace_checker.sv | 189 ++++++++++++++++++
 tb/tb_wb_trace_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker.sv
// Writeback-stream checker: buffers expected values, then compares core writebacks in order
// and ends in pass, mismatch or timeout status with a saturating RUN cycle count.
module wb_trace_checker #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exp_load,
    input  logic [WIDTH-1:0]           exp_data,
    input  logic                       start,
    input  logic                       clear,
    input  logic                       wb_valid,
    input  logic [WIDTH-1:0]           writedata,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic                       overflow,
    output logic [$clog2(DEPTH)-1:0]   err_index,
    output logic [$clog2(DEPTH):0]     match_count,
    output logic [WIDTH-1:0]           err_data,
    output logic [CNT_W-1:0]           cycle_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CW    = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CW-1:0]      r_count;
    logic [IDX_W-1:0]   r_wr_ptr;
    logic [IDX_W-1:0]   r_rd_ptr;
    logic [WIDTH-1:0]   r_buf [DEPTH];

    logic w_load;
    logic w_ovf_set;
    logic w_start;
    logic w_match;
    logic w_miss;
    logic w_pass;
    logic w_tmo;
    logic w_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and per-cycle decisions; a final match takes priority over timeout.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_ovf_set  = 1'b0;
        w_start    = 1'b0;
        w_match    = 1'b0;
        w_miss     = 1'b0;
        w_pass     = 1'b0;
        w_tmo      = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (exp_load) begin
                    if (r_count == CW'(DEPTH)) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end
                if (start) begin
                    w_start    = 1'b1;
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == '0) begin
                    w_pass = 1'b1;
                end else if (wb_valid) begin
                    if (writedata == r_buf[r_rd_ptr]) begin
                        w_match = 1'b1;
                        w_pass  = ((match_count + CW'(1)) == r_count);
                    end else begin
                        w_miss = 1'b1;
                    end
                end
                if (!w_pass && !w_miss && (cycle_count == CNT_W'(TIMEOUT - 1))) begin
                    w_tmo = 1'b1;
                end
                if (w_pass || w_miss || w_tmo) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (clear) begin
                    w_clear    = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Expected-value storage; contents are don't-care until loaded.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_buf[r_wr_ptr] <= exp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
            err_index   <= '0;
            err_data    <= '0;
            match_count <= '0;
            cycle_count <= '0;
        end else begin
            busy <= (w_state_nx == S_RUN);
            done <= (w_state_nx == S_DONE);
            if (w_load) begin
                r_wr_ptr <= r_wr_ptr + IDX_W'(1);
                r_count  <= r_count + CW'(1);
            end
            if (w_ovf_set) begin
                overflow <= 1'b1;
            end
            if (w_start) begin
                r_rd_ptr    <= '0;
                match_count <= '0;
                cycle_count <= '0;
            end
            if (r_state == S_RUN && cycle_count != '1) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (w_match) begin
                r_rd_ptr    <= r_rd_ptr + IDX_W'(1);
                match_count <= match_count + CW'(1);
            end
            if (w_miss) begin
                err_index <= r_rd_ptr;
                err_data  <= writedata;
                fail      <= 1'b1;
            end
            if (w_pass) begin
                pass <= 1'b1;
            end
            if (w_tmo) begin
                fail    <= 1'b1;
                timeout <= 1'b1;
            end
            if (w_clear) begin
                r_count     <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                pass        <= 1'b0;
                fail        <= 1'b0;
                timeout     <= 1'b0;
                overflow    <= 1'b0;
                err_index   <= '0;
                err_data    <= '0;
                match_count <= '0;
                cycle_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal results.
module tb_wb_trace_checker;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              exp_load = 1'b0;
    logic [WIDTH-1:0]  exp_data = '0;
    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic              wb_valid = 1'b0;
    logic [WIDTH-1:0]  writedata = '0;
    logic              busy, done, pass, fail, timeout, overflow;
    logic [3:0]        err_index;
    logic [4:0]        match_count;
    logic [WIDTH-1:0]  err_data;
    logic [CNT_W-1:0]  cycle_count;

    int n_checks = 0;
    int n_err    = 0;

    wb_trace_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .exp_load(exp_load), .exp_data(exp_data), .start(start),
        .clear(clear), .wb_valid(wb_valid), .writedata(writedata), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .timeout(timeout), .overflow(overflow),
        .err_index(err_index), .match_count(match_count), .err_data(err_data),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 running, 2 finished; pending expectations live in a queue.
    logic [WIDTH-1:0] m_q[$];
    int               m_phase = 0;
    int               m_hits = 0;
    int               m_cycles = 0;
    bit               m_pass = 0, m_fail = 0, m_tmo = 0, m_ovf = 0;
    int               m_eidx = 0;
    logic [WIDTH-1:0] m_edata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_phase = 0; m_hits = 0; m_cycles = 0;
            m_pass = 0; m_fail = 0; m_tmo = 0; m_ovf = 0; m_eidx = 0; m_edata = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (exp_load) begin
                        if (m_q.size() == DEPTH) m_ovf = 1;
                        else m_q.push_back(exp_data);
                    end
                    if (start) begin
                        m_phase = 1; m_hits = 0; m_cycles = 0;
                    end
                end
                1: begin
                    if (m_cycles < (1 << CNT_W) - 1) m_cycles++;
                    if (m_q.size() == 0) begin
                        m_pass = 1;
                    end else if (wb_valid && writedata == m_q[0]) begin
                        void'(m_q.pop_front());
                        m_hits++;
                        if (m_q.size() == 0) m_pass = 1;
                    end else if (wb_valid) begin
                        m_fail = 1; m_eidx = m_hits; m_edata = writedata;
                    end
                    if (!m_pass && !m_fail && m_cycles == TIMEOUT) begin
                        m_fail = 1; m_tmo = 1;
                    end
                    if (m_pass || m_fail) m_phase = 2;
                end
                default: begin
                    if (clear) begin
                        m_q.delete();
                        m_phase = 0; m_hits = 0; m_cycles = 0;
                        m_pass = 0; m_fail = 0; m_tmo = 0; m_ovf = 0; m_eidx = 0; m_edata = '0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_phase == 1));
        chk("done", 64'(done), 64'(m_phase == 2));
        chk("pass", 64'(pass), 64'(m_pass));
        chk("fail", 64'(fail), 64'(m_fail));
        chk("timeout", 64'(timeout), 64'(m_tmo));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("match_count", 64'(match_count), 64'(m_hits));
        chk("cycle_count", 64'(cycle_count), 64'(m_cycles));
        chk("err_index", 64'(err_index), 64'(m_eidx));
        chk("err_data", 64'(err_data), 64'(m_edata));
        chk("pass_fail_excl", 64'(pass & fail), 64'(0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        exp_load = 1'b1; exp_data = v;
        tick();
        exp_load = 1'b0;
    endtask

    task automatic wb(input logic [WIDTH-1:0] v);
        wb_valid = 1'b1; writedata = v;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk("wait_done_bound", 64'(done), 64'(1));
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick();
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        rst = 1'b0;
        tick();

        // 1: three in-order matches; stray wb_valid and clear in IDLE are ignored
        wb(32'hDEAD);
        do_clear();
        load(3); load(5); load(8);
        go();
        chk("s1_busy", 64'(busy), 64'(1));
        wb(3); wb(5); wb(8);
        chk("s1_pass", 64'(pass), 64'(1));
        chk("s1_match", 64'(match_count), 64'(3));
        chk("s1_fail", 64'(fail), 64'(0));
        chk("s1_tmo", 64'(timeout), 64'(0));
        do_clear();

        // 2: mismatch on second writeback; exp_load in RUN ignored
        load(3); load(5); load(8);
        go();
        load(99);
        wb(3); tick(); wb(7);
        chk("s2_fail", 64'(fail), 64'(1));
        chk("s2_eidx", 64'(err_index), 64'(1));
        chk("s2_edata", 64'(err_data), 64'(7));
        chk("s2_match", 64'(match_count), 64'(1));
        chk("s2_tmo", 64'(timeout), 64'(0));
        wb(5);
        chk("s2_hold", 64'(match_count), 64'(1));
        do_clear();

        // 3: no writebacks -> timeout
        load(32'h1234_5678);
        go();
        wait_done(TIMEOUT + 10);
        chk("s3_fail", 64'(fail), 64'(1));
        chk("s3_tmo", 64'(timeout), 64'(1));
        chk("s3_cycles", 64'(cycle_count), 64'(40));
        do_clear();

        // 4: DEPTH+1 loads overflow; full buffer still passes
        for (int i = 0; i < DEPTH + 1; i++) load(WIDTH'(i * 11 + 1));
        chk("s4_ovf", 64'(overflow), 64'(1));
        go();
        for (int i = 0; i < DEPTH; i++) wb(WIDTH'(i * 11 + 1));
        chk("s4_pass", 64'(pass), 64'(1));
        chk("s4_match", 64'(match_count), 64'(16));
        do_clear();
        chk("s4_ovf_clr", 64'(overflow), 64'(0));

        // 5: empty buffer passes after one RUN cycle
        go();
        tick();
        chk("s5_pass", 64'(pass), 64'(1));
        chk("s5_cycles", 64'(cycle_count), 64'(1));
        do_clear();
        chk("s5_done_clr", 64'(done), 64'(0));
        chk("s5_pass_clr", 64'(pass), 64'(0));

        // 6: reset mid-RUN clears everything immediately, buffer included
        load(10); load(20); load(30); load(40);
        go();
        wb(10); wb(20);
        rst = 1'b1;
        #1;
        chk("s6_busy", 64'(busy), 64'(0));
        chk("s6_match", 64'(match_count), 64'(0));
        chk("s6_cycles", 64'(cycle_count), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        go();
        tick();
        chk("s6_empty_pass", 64'(pass), 64'(1));
        do_clear();

        // 7: final match on the timeout cycle wins
        load(77);
        go();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        wb(77);
        chk("s7_pass", 64'(pass), 64'(1));
        chk("s7_tmo", 64'(timeout), 64'(0));
        chk("s7_cycles", 64'(cycle_count), 64'(40));
        do_clear();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
